// File: rtl/data_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_if
//   Request/response bus between a load/store unit (master) and the data
//   memory controller (slave).
//
//   Request channel  : req_valid/req_ready handshake carrying req_write,
//                      req_addr (byte address), req_size (0 byte, 1 half,
//                      2 word, 3 reserved), req_unsigned, req_wdata.
//   Response channel : resp_valid/resp_ready handshake carrying resp_rdata
//                      (extended load data) and resp_err.
// ----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned,
               req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned,
               req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
//   Byte-addressed array of MEM_DEPTH 32-bit words behind a valid/ready
//   request and response handshake. One access is outstanding at a time;
//   the response appears LATENCY (1..15) cycles after the request is
//   accepted and is held until the consumer takes it.
//
//   Supports byte/half/word stores (byte-enable lane writes) and loads
//   (sign- or zero-extended). Faults (word index out of range, reserved
//   size, trapped misalignment) return resp_err = 1 with resp_rdata = 0
//   and never write the array.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous, active-low reset (array contents are kept)
//     bus      data_mem_ctrl_if.slave request/response bus
//
//   Build option:
//     DMEM_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses fault
//                            undefined : misaligned low address bits are
//                                        cleared to natural alignment
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LATENCY   = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    data_mem_ctrl_if.slave bus
);

    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(MEM_DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]        r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [31:0] r_mem [MEM_DEPTH];

    logic [WIDX_W-1:0] w_word_idx;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [1:0]        w_lane;
    logic              w_misalign;
    logic              w_oob;
    logic              w_err;
    logic [3:0]        w_be;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_shifted;
    logic [31:0]       w_wdata_sh;
    logic [31:0]       w_ext;
    logic [31:0]       w_load_data;
    logic              w_access;
    logic              w_commit;

    // ------------------------------------------------------------------
    // Decode of the latched request
    // ------------------------------------------------------------------
    assign w_word_idx = r_addr[ADDR_W-1:2];
    assign w_mem_idx  = w_word_idx[IDX_W-1:0];
    assign w_oob      = (w_word_idx >= DEPTH_LIM);

    always_comb begin
        w_lane     = r_addr[1:0];
        w_misalign = 1'b0;
        case (r_size)
            SZ_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                w_misalign = r_addr[0];
`else
                w_lane     = {r_addr[1], 1'b0};
`endif
            end
            SZ_WORD: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                w_misalign = (r_addr[1:0] != 2'b00);
`else
                w_lane     = 2'b00;
`endif
            end
            default: begin
                w_lane     = r_addr[1:0];
                w_misalign = 1'b0;
            end
        endcase
    end

    assign w_err = w_oob | (r_size == 2'd3) | w_misalign;

    // Lane is already naturally aligned here, so shifting the base
    // enable pattern by the lane selects the right bytes for every size.
    always_comb begin
        case (r_size)
            SZ_BYTE: w_be = 4'b0001 << w_lane;
            SZ_HALF: w_be = 4'b0011 << w_lane;
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_rd_word  = r_mem[w_mem_idx];
    assign w_shifted  = w_rd_word >> {w_lane, 3'b000};
    assign w_wdata_sh = r_wdata << {w_lane, 3'b000};

    always_comb begin
        case (r_size)
            SZ_BYTE: w_ext = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: w_ext = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            SZ_WORD: w_ext = w_rd_word;
            default: w_ext = '0;
        endcase
    end

    assign w_load_data = (r_write | w_err) ? '0 : w_ext;

    // Access edge: last WAIT cycle. State is forced to IDLE by reset, so an
    // aborted access can never reach the commit.
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_commit = w_access && r_write && !w_err;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated with reset_n so req_ready stays low while in reset.
                bus.req_ready = reset_n;
                if (bus.req_valid) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // ------------------------------------------------------------------
    // Request capture, latency counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_cnt      <= LAT_M1;
                        r_write    <= bus.req_write;
                        r_addr     <= bus.req_addr;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_wdata    <= bus.req_wdata;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= w_load_data;
                        r_err   <= w_err;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: byte-lane writes, no reset so contents survive reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Two controllers (LATENCY 1 and LATENCY 4) share one stimulus driver; sel
//   chooses which one the request valid goes to and which one is observed.
//   Directed vectors, hand-written multi-cycle sequences (backpressure,
//   same-edge request after response, async reset abort) and a randomized
//   phase checked against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(32)) bus1 ();
    data_mem_ctrl_if #(.ADDR_W(32)) bus4 ();

    data_mem_ctrl #(.MEM_DEPTH(16384), .ADDR_W(32), .LATENCY(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    data_mem_ctrl #(.MEM_DEPTH(16384), .ADDR_W(32), .LATENCY(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    logic        sel = 1'b0;
    logic        t_req_valid = 1'b0;
    logic        t_write = 1'b0;
    logic [31:0] t_addr = '0;
    logic [1:0]  t_size = '0;
    logic        t_uns = 1'b0;
    logic [31:0] t_wdata = '0;
    logic        t_resp_ready = 1'b0;

    assign bus1.req_valid    = t_req_valid & ~sel;
    assign bus4.req_valid    = t_req_valid & sel;
    assign bus1.req_write    = t_write;
    assign bus4.req_write    = t_write;
    assign bus1.req_addr     = t_addr;
    assign bus4.req_addr     = t_addr;
    assign bus1.req_size     = t_size;
    assign bus4.req_size     = t_size;
    assign bus1.req_unsigned = t_uns;
    assign bus4.req_unsigned = t_uns;
    assign bus1.req_wdata    = t_wdata;
    assign bus4.req_wdata    = t_wdata;
    assign bus1.resp_ready   = t_resp_ready;
    assign bus4.resp_ready   = t_resp_ready;

    logic        o_req_ready;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    assign o_req_ready  = sel ? bus4.req_ready  : bus1.req_ready;
    assign o_resp_valid = sel ? bus4.resp_valid : bus1.resp_valid;
    assign o_resp_rdata = sel ? bus4.resp_rdata : bus1.resp_rdata;
    assign o_resp_err   = sel ? bus4.resp_err   : bus1.resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction with resp_ready held high. Returns the
    // response fields and the number of edges from accept to resp_valid.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wd,
                             output logic [31:0] rd, output logic err, output int lat);
        int wc;
        @(negedge clk);
        t_write = wr; t_addr = addr; t_size = size; t_uns = uns; t_wdata = wd;
        t_req_valid = 1'b1; t_resp_ready = 1'b1;
        wc = 0;
        while (!o_req_ready && wc < 20) begin @(negedge clk); wc++; end
        @(posedge clk); #1;
        t_req_valid = 1'b0;
        lat = 0;
        while (!o_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rd  = o_resp_rdata;
        err = o_resp_err;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-addressed store, rules applied directly
    // ------------------------------------------------------------------
    logic [7:0] mm [logic [31:0]];

    function automatic void model(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int unsigned n;
        logic [31:0] ea;
        logic [31:0] v;
        logic        misal;
        n     = 1 << sz;
        ea    = a;
        misal = (sz != 2'd3) && ((a % n) != 0);
        err   = (sz == 2'd3) || ((a >> 2) >= 32'd16384);
`ifdef DMEM_MISALIGN_TRAP_EN
        err = err || misal;
`else
        if (misal) ea = a - (a % n);
`endif
        rd = '0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < int'(n); i++) mm[ea + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < int'(n); i++) v = v | (32'(mm[ea + i]) << (8*i));
                if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wd;
        v.exp_rd = erd; v.exp_err = eerr;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, snap, erd, wd, a;
        logic        er, eer, wr, uns, seen;
        logic [1:0]  sz;
        int          lat;

        // ---------------- reset state ----------------
        #2 reset_n = 1'b0;
        #3;
        chk("rst dut1 req_ready",  32'(bus1.req_ready),  32'd0);
        chk("rst dut1 resp_valid", 32'(bus1.resp_valid), 32'd0);
        chk("rst dut1 resp_rdata", bus1.resp_rdata,      32'd0);
        chk("rst dut1 resp_err",   32'(bus1.resp_err),   32'd0);
        chk("rst dut4 req_ready",  32'(bus4.req_ready),  32'd0);
        chk("rst dut4 resp_valid", 32'(bus4.resp_valid), 32'd0);
        #17 reset_n = 1'b1;
        @(negedge clk);
        chk("post-rst req_ready", 32'(o_req_ready), 32'd1);

        // ---------------- directed vectors, LATENCY 1 ----------------
        add(1, 32'h0000_0000, 2, 0, 32'h0F0F_0F0F, 32'h0, 0);
        add(1, 32'h0000_0040, 2, 0, 32'hDEAD_BEEF, 32'h0, 0);
        add(0, 32'h0000_0040, 2, 0, 32'h0,         32'hDEAD_BEEF, 0);
        add(1, 32'h0000_0080, 2, 0, 32'h1122_3344, 32'h0, 0);
        add(1, 32'h0000_0082, 0, 0, 32'h0000_00AA, 32'h0, 0);
        add(0, 32'h0000_0080, 2, 0, 32'h0,         32'h11AA_3344, 0);
        add(0, 32'h0000_0082, 0, 0, 32'h0,         32'hFFFF_FFAA, 0);
        add(0, 32'h0000_0082, 0, 1, 32'h0,         32'h0000_00AA, 0);
        add(0, 32'h0000_0083, 0, 0, 32'h0,         32'h0000_0011, 0);
        add(1, 32'h0000_0100, 2, 0, 32'h8001_7FFE, 32'h0, 0);
        add(0, 32'h0000_0102, 1, 0, 32'h0,         32'hFFFF_8001, 0);
        add(0, 32'h0000_0102, 1, 1, 32'h0,         32'h0000_8001, 0);
        add(0, 32'h0000_0100, 1, 0, 32'h0,         32'h0000_7FFE, 0);
        add(1, 32'h0000_0102, 1, 0, 32'hFFFF_1234, 32'h0, 0);
        add(0, 32'h0000_0100, 2, 0, 32'h0,         32'h1234_7FFE, 0);
        add(1, 32'h0001_0000, 2, 0, 32'h5555_5555, 32'h0, 1);
        add(0, 32'h0001_0000, 2, 0, 32'h0,         32'h0, 1);
        add(0, 32'h0000_0000, 2, 0, 32'h0,         32'h0F0F_0F0F, 0);
        add(1, 32'h0000_0040, 3, 0, 32'h0,         32'h0, 1);
        add(0, 32'h0000_0040, 3, 0, 32'h0,         32'h0, 1);
        add(0, 32'h0000_0040, 2, 0, 32'h0,         32'hDEAD_BEEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        add(1, 32'h0000_0041, 2, 0, 32'hA5A5_A5A5, 32'h0, 1);
        add(0, 32'h0000_0040, 2, 0, 32'h0,         32'hDEAD_BEEF, 0);
        add(0, 32'h0000_0081, 1, 0, 32'h0,         32'h0, 1);
`else
        add(1, 32'h0000_0041, 2, 0, 32'hA5A5_A5A5, 32'h0, 0);
        add(0, 32'h0000_0040, 2, 0, 32'h0,         32'hA5A5_A5A5, 0);
        add(0, 32'h0000_0081, 1, 0, 32'h0,         32'h0000_3344, 0);
`endif

        sel = 1'b0;
        foreach (vecs[k]) begin
            do_access(vecs[k].wr, vecs[k].addr, vecs[k].size, vecs[k].uns, vecs[k].wdata, rd, er, lat);
            chk($sformatf("vec%0d rdata", k), rd, vecs[k].exp_rd);
            chk($sformatf("vec%0d err", k), 32'(er), 32'(vecs[k].exp_err));
            chk($sformatf("vec%0d latency", k), 32'(lat), 32'd1);
            chk($sformatf("vec%0d valid drop", k), 32'(o_resp_valid), 32'd0);
            chk($sformatf("vec%0d ready back", k), 32'(o_req_ready), 32'd1);
        end

        // ---------------- latency 4 with backpressure ----------------
        sel = 1'b1;
        do_access(1, 32'h20, 2, 0, 32'h1234_5678, rd, er, lat);
        chk("l4 store latency", 32'(lat), 32'd4);
        @(negedge clk);
        t_write = 0; t_addr = 32'h20; t_size = 2; t_uns = 0; t_req_valid = 1; t_resp_ready = 0;
        @(posedge clk); #1;
        t_req_valid = 0;
        chk("l4 ready low in wait", 32'(o_req_ready), 32'd0);
        lat = 0;
        while (!o_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("l4 load latency", 32'(lat), 32'd4);
        snap = o_resp_rdata;
        chk("l4 load rdata", snap, 32'h1234_5678);
        chk("l4 load err", 32'(o_resp_err), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d valid", c), 32'(o_resp_valid), 32'd1);
            chk($sformatf("stall%0d rdata", c), o_resp_rdata, snap);
            chk($sformatf("stall%0d ready", c), 32'(o_req_ready), 32'd0);
        end
        // New request presented on the same edge as the response handshake.
        t_resp_ready = 1; t_write = 1; t_addr = 32'h24; t_size = 2; t_wdata = 32'h55AA_55AA;
        t_req_valid = 1;
        @(posedge clk); #1;
        chk("hs valid drop", 32'(o_resp_valid), 32'd0);
        chk("hs ready next cycle", 32'(o_req_ready), 32'd1);
        @(posedge clk); #1;
        t_req_valid = 0;
        chk("late accept ready low", 32'(o_req_ready), 32'd0);
        lat = 0;
        while (!o_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("late accept latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        do_access(0, 32'h24, 2, 0, 32'h0, rd, er, lat);
        chk("late accept stored", rd, 32'h55AA_55AA);

        // ---------------- async reset abort ----------------
        do_access(1, 32'h200, 2, 0, 32'hCAFE_F00D, rd, er, lat);
        do_access(0, 32'h200, 2, 0, 32'h0, rd, er, lat);
        chk("old 0x200", rd, 32'hCAFE_F00D);
        @(negedge clk);
        t_write = 1; t_addr = 32'h200; t_size = 2; t_wdata = 32'h0BAD_BEEF; t_req_valid = 1;
        @(posedge clk); #1;
        t_req_valid = 0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("abort req_ready",  32'(o_req_ready),  32'd0);
        chk("abort resp_valid", 32'(o_resp_valid), 32'd0);
        chk("abort resp_rdata", o_resp_rdata,      32'd0);
        chk("abort resp_err",   32'(o_resp_err),   32'd0);
        #2 reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (o_resp_valid) seen = 1'b1;
        end
        chk("abort no response", 32'(seen), 32'd0);
        do_access(0, 32'h200, 2, 0, 32'h0, rd, er, lat);
        chk("abort store dropped", rd, 32'hCAFE_F00D);

        // ---------------- randomized vs reference model ----------------
        sel = 1'b0;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model(1, 32'h400 + 32'(4*w), 2, 0, wd, erd, eer);
            do_access(1, 32'h400 + 32'(4*w), 2, 0, wd, rd, er, lat);
            chk($sformatf("init%0d err", w), 32'(er), 32'(eer));
        end
        for (int k = 0; k < 300; k++) begin
            wr  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h1_0400 + $urandom_range(0, 255);
            else                          a = 32'h400 + $urandom_range(0, 255);
            model(wr, a, sz, uns, wd, erd, eer);
            do_access(wr, a, sz, uns, wd, rd, er, lat);
            chk($sformatf("rand%0d a=%08h sz=%0d wr=%0d rdata", k, a, sz, wr), rd, erd);
            chk($sformatf("rand%0d a=%08h sz=%0d wr=%0d err", k, a, sz, wr), 32'(er), 32'(eer));
            chk($sformatf("rand%0d latency", k), 32'(lat), 32'd1);
        end
        for (int w = 0; w < 64; w++) begin
            model(0, 32'h400 + 32'(4*w), 2, 0, 32'h0, erd, eer);
            do_access(0, 32'h400 + 32'(4*w), 2, 0, 32'h0, rd, er, lat);
            chk($sformatf("final%0d rdata", w), rd, erd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
